trakball_qdec: RTL and testbench

- Converts the trackball's raw quadrature signals into the 8-bit `trakball_i` value the centipede core reads: two 4-bit wrapping position counters plus direction flags.
- Sits between the board pins (or pushbuttons) and the game core, in the `clk12m` domain.
- Includes an emulation mode: held buttons step the counters at a fixed rate, so boards without a trackball remain playable.

---
 rtl/trakball_qdec.sv | 146 ++++++++++++++
 tb/tb_trakball_qdec.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/trakball_qdec.sv
// Trackball quadrature decoder: synchronizes and filters the two {A,B} pairs, decodes them into
// 4-bit wrapping position counters, and can instead step the counters from emulation buttons.
module trakball_qdec #(
   parameter int unsigned FILT_CYC = 4,
   parameter int unsigned EMU_DIV  = 12000
) (
   input  logic       clk12m,
   input  logic       reset,
   input  logic       qa_h,
   input  logic       qb_h,
   input  logic       qa_v,
   input  logic       qb_v,
   input  logic       emu_en,
   input  logic       emu_left,
   input  logic       emu_right,
   input  logic       emu_up,
   input  logic       emu_down,
   output logic [7:0] trakball_o,
   output logic       dir_h_o,
   output logic       dir_v_o,
   output logic       err_o
);

   localparam int unsigned     DivW    = $clog2(EMU_DIV);
   localparam logic [3:0]      FiltMax = 4'(FILT_CYC - 1);
   localparam logic [DivW-1:0] DivMax  = DivW'(EMU_DIV - 1);

   // Index 0 is the horizontal axis, index 1 the vertical axis.
   logic [1:0][1:0] raw;
   logic [1:0][1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0][1:0] cand_q, cand_d, acc_q, acc_d;
   logic [1:0][3:0] fcnt_q, fcnt_d, pos_q, pos_d;
   logic [1:0]      dir_q, dir_d, init_q, init_d;
   logic [1:0]      emu_inc, emu_dec;
   logic            err_q, err_d;
   logic [DivW-1:0] div_q, div_d;
   logic            tick;
   logic            accept;
   logic [1:0]      step;

   assign raw[0]  = {qa_h, qb_h};
   assign raw[1]  = {qa_v, qb_v};
   assign tick    = emu_en && (div_q == DivMax);
   assign emu_inc = {emu_up & ~emu_down, emu_right & ~emu_left};
   assign emu_dec = {emu_down & ~emu_up, emu_left & ~emu_right};

   // Position of a state along the +1 cycle 00,01,11,10.
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      cand_d  = cand_q;
      fcnt_d  = fcnt_q;
      acc_d   = acc_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      init_d  = init_q;
      err_d   = err_q;
      accept  = 1'b0;
      step    = 2'd0;
      div_d   = '0;
      if (emu_en) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end

      for (int ax = 0; ax < 2; ax++) begin
         if (sync2_q[ax] != cand_q[ax]) begin
            cand_d[ax] = sync2_q[ax];
            fcnt_d[ax] = 4'd0;
         end else if (fcnt_q[ax] != FiltMax) begin
            fcnt_d[ax] = fcnt_q[ax] + 4'd1;
         end

         accept = (fcnt_q[ax] == FiltMax) && ((cand_q[ax] != acc_q[ax]) || init_q[ax]);
         step   = gray_idx(cand_q[ax]) - gray_idx(acc_q[ax]);
         if (accept) begin
            acc_d[ax] = cand_q[ax];
            if (!emu_en) begin
               if (init_q[ax]) begin
                  init_d[ax] = 1'b0;
               end else begin
                  case (step)
                     2'd1: begin
                        pos_d[ax] = pos_q[ax] + 4'd1;
                        dir_d[ax] = 1'b0;
                     end
                     2'd3: begin
                        pos_d[ax] = pos_q[ax] - 4'd1;
                        dir_d[ax] = 1'b1;
                     end
                     2'd2:    err_d = 1'b1;
                     default: ;
                  endcase
               end
            end
         end

         // Holding init while emulating makes the first accepted value after exit a silent reload.
         if (emu_en) begin
            init_d[ax] = 1'b1;
            if (tick && emu_inc[ax]) begin
               pos_d[ax] = pos_q[ax] + 4'd1;
               dir_d[ax] = 1'b0;
            end else if (tick && emu_dec[ax]) begin
               pos_d[ax] = pos_q[ax] - 4'd1;
               dir_d[ax] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk12m or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         fcnt_q  <= '0;
         acc_q   <= '0;
         pos_q   <= '0;
         dir_q   <= '0;
         init_q  <= '1;
         err_q   <= 1'b0;
         div_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cand_q  <= cand_d;
         fcnt_q  <= fcnt_d;
         acc_q   <= acc_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         init_q  <= init_d;
         err_q   <= err_d;
         div_q   <= div_d;
      end
   end

   assign trakball_o = {pos_q[1], pos_q[0]};
   assign dir_h_o    = dir_q[0];
   assign dir_v_o    = dir_q[1];
   assign err_o      = err_q;

endmodule

// File: tb/tb_trakball_qdec.sv
// Directed bench for trakball_qdec (FILT_CYC=4, EMU_DIV=10); each task checks its own scenario.
module tb_trakball_qdec;

   logic       clk12m = 1'b0;
   logic       reset = 1'b0;
   logic       qa_h = 1'b0, qb_h = 1'b0, qa_v = 1'b0, qb_v = 1'b0;
   logic       emu_en = 1'b0;
   logic       emu_left = 1'b0, emu_right = 1'b0, emu_up = 1'b0, emu_down = 1'b0;
   logic [7:0] trakball_o;
   logic       dir_h_o, dir_v_o, err_o;
   int         checks = 0;
   int         errors = 0;

   trakball_qdec #(
      .FILT_CYC(4),
      .EMU_DIV (10)
   ) dut (
      .clk12m    (clk12m),
      .reset     (reset),
      .qa_h      (qa_h),
      .qb_h      (qb_h),
      .qa_v      (qa_v),
      .qb_v      (qb_v),
      .emu_en    (emu_en),
      .emu_left  (emu_left),
      .emu_right (emu_right),
      .emu_up    (emu_up),
      .emu_down  (emu_down),
      .trakball_o(trakball_o),
      .dir_h_o   (dir_h_o),
      .dir_v_o   (dir_v_o),
      .err_o     (err_o)
   );

   always #5 clk12m = ~clk12m;

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk12m);
      #1;
   endtask

   task automatic set_h(input logic [1:0] ab, input int hold);
      {qa_h, qb_h} = ab;
      cyc(hold);
   endtask

   task automatic set_v(input logic [1:0] ab, input int hold);
      {qa_v, qb_v} = ab;
      cyc(hold);
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (trakball_o !== 8'h00) begin
         errors++; $display("FAIL reset_count got %h want 00", trakball_o);
      end
      checks++;
      if ({dir_h_o, dir_v_o, err_o} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b want 000", {dir_h_o, dir_v_o, err_o});
      end
      cyc(2);
      reset = 1'b0;
      cyc(20);
      checks++;
      if (trakball_o !== 8'h00) begin
         errors++; $display("FAIL idle_count got %h want 00", trakball_o);
      end
      checks++;
      if ({dir_h_o, dir_v_o, err_o} !== 3'b000) begin
         errors++; $display("FAIL idle_flags got %b want 000", {dir_h_o, dir_v_o, err_o});
      end
   endtask

   task automatic test_h_forward;
      set_h(2'b01, 6);
      checks++;
      if (trakball_o !== 8'h00) begin
         errors++; $display("FAIL h_latency_early got %h want 00", trakball_o);
      end
      cyc(1);
      checks++;
      if (trakball_o !== 8'h01) begin
         errors++; $display("FAIL h_latency_edge got %h want 01", trakball_o);
      end
      cyc(3);
      set_h(2'b11, 10);
      set_h(2'b10, 10);
      set_h(2'b00, 10);
      checks++;
      if (trakball_o !== 8'h04) begin
         errors++; $display("FAIL h_forward_count got %h want 04", trakball_o);
      end
      checks++;
      if ({dir_h_o, dir_v_o, err_o} !== 3'b000) begin
         errors++; $display("FAIL h_forward_flags got %b want 000", {dir_h_o, dir_v_o, err_o});
      end
   endtask

   task automatic test_v_reverse;
      set_v(2'b00, 10);
      set_v(2'b10, 10);
      set_v(2'b11, 10);
      set_v(2'b01, 10);
      set_v(2'b00, 10);
      set_v(2'b10, 10);
      checks++;
      if (trakball_o !== 8'hB4) begin
         errors++; $display("FAIL v_reverse_count got %h want b4", trakball_o);
      end
      checks++;
      if ({dir_h_o, dir_v_o, err_o} !== 3'b010) begin
         errors++; $display("FAIL v_reverse_flags got %b want 010", {dir_h_o, dir_v_o, err_o});
      end
   endtask

   task automatic test_glitch_and_illegal;
      set_h(2'b01, 2);
      set_h(2'b00, 12);
      checks++;
      if (trakball_o !== 8'hB4) begin
         errors++; $display("FAIL glitch_count got %h want b4", trakball_o);
      end
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL glitch_err got %b want 0", err_o);
      end
      set_h(2'b11, 10);
      checks++;
      if (trakball_o !== 8'hB4) begin
         errors++; $display("FAIL illegal_count got %h want b4", trakball_o);
      end
      checks++;
      if ({dir_h_o, dir_v_o, err_o} !== 3'b011) begin
         errors++; $display("FAIL illegal_flags got %b want 011", {dir_h_o, dir_v_o, err_o});
      end
   endtask

   task automatic test_emulation;
      // Horizontal pins move 11->01 while emulating; must not count on return.
      emu_en = 1'b1;
      emu_right = 1'b1;
      set_h(2'b01, 9);
      checks++;
      if (trakball_o !== 8'hB4) begin
         errors++; $display("FAIL emu_before_tick got %h want b4", trakball_o);
      end
      cyc(1);
      checks++;
      if (trakball_o !== 8'hB5) begin
         errors++; $display("FAIL emu_first_tick got %h want b5", trakball_o);
      end
      cyc(45);
      checks++;
      if (trakball_o !== 8'hB9 || dir_h_o !== 1'b0) begin
         errors++; $display("FAIL emu_right got %h/%b want b9/0", trakball_o, dir_h_o);
      end
      emu_left = 1'b1;
      cyc(30);
      checks++;
      if (trakball_o !== 8'hB9) begin
         errors++; $display("FAIL emu_both got %h want b9", trakball_o);
      end
      emu_left = 1'b0;
      emu_right = 1'b0;
      emu_up = 1'b1;
      cyc(10);
      checks++;
      if (trakball_o !== 8'hC9 || dir_v_o !== 1'b0) begin
         errors++; $display("FAIL emu_up got %h/%b want c9/0", trakball_o, dir_v_o);
      end
      emu_up = 1'b0;
      emu_en = 1'b0;
      cyc(20);
      checks++;
      if (trakball_o !== 8'hC9) begin
         errors++; $display("FAIL emu_exit_count got %h want c9", trakball_o);
      end
      checks++;
      if (err_o !== 1'b1) begin
         errors++; $display("FAIL err_sticky got %b want 1", err_o);
      end
      set_h(2'b11, 10);
      checks++;
      if (trakball_o !== 8'hCA || dir_h_o !== 1'b0) begin
         errors++; $display("FAIL emu_exit_step got %h/%b want ca/0", trakball_o, dir_h_o);
      end
   endtask

   task automatic test_reset_mid;
      set_h(2'b10, 3);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (trakball_o !== 8'h00) begin
         errors++; $display("FAIL mid_reset_count got %h want 00", trakball_o);
      end
      checks++;
      if ({dir_h_o, dir_v_o, err_o} !== 3'b000) begin
         errors++; $display("FAIL mid_reset_flags got %b want 000", {dir_h_o, dir_v_o, err_o});
      end
      {qa_h, qb_h} = 2'b11;
      cyc(2);
      reset = 1'b0;
      cyc(20);
      checks++;
      if (trakball_o !== 8'h00 || err_o !== 1'b0) begin
         errors++; $display("FAIL init_load got %h/%b want 00/0", trakball_o, err_o);
      end
      set_h(2'b10, 10);
      checks++;
      if (trakball_o !== 8'h01 || dir_h_o !== 1'b0) begin
         errors++; $display("FAIL post_init_step got %h/%b want 01/0", trakball_o, dir_h_o);
      end
   endtask

   initial begin
      test_reset();
      test_h_forward();
      test_v_reverse();
      test_glitch_and_illegal();
      test_emulation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
